sqrt_share_sched: RTL
=====================

// Module: sqrt_share_sched
// PURPOSE
//  Round-robin scheduler that time-shares one iterative square-root engine among NREQ requesters.
//  It replaces per-term combinational sqrt instances in the geofence datapath, which need side
//  lengths and Heron terms. It arbitrates, captures the winning radicand, runs a digit-by-digit
//  restoring sqrt, and returns floor(sqrt(din)) tagged with the requester id.
// PARAMETERS
//  NREQ  6   number of requesters (2..8)
//  DW    40  radicand width, even
//  QW    20  root width, must equal DW/2
//  IDW   3   id width, must be >= clog2(NREQ)
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  req        in   NREQ     level request; bit i belongs to requester i
//  din        in   NREQ*DW  radicands; requester i uses din[i*DW +: DW]
//  ack        out  NREQ     one-hot, one-cycle pulse: request i accepted, din[i] captured
//  busy       out  1        engine occupied (CALC or DONE)
//  rsp_valid  out  1        one-cycle pulse: result valid
//  rsp_id     out  IDW      requester index for the result
//  rsp_data   out  QW       floor(sqrt(captured radicand))
// BEHAVIOUR
//  - Reset, asynchronous: state=IDLE; ack=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0.
//    Internally, last_id=NREQ-1 (so req[0] has top priority after reset), root=0, rem=0.
//  - Reset mid-CALC/DONE aborts the operation; no rsp_valid is ever issued for it.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: at an edge where req!=0, the grant goes to the first set bit searching from
//    last_id+1 upward, with wrap modulo NREQ.
//    - On that same edge: capture din slice, set id, last_id=id, cnt=0, go to CALC.
//    - ack[id]=1 for exactly the following cycle.
//    - If req==0, stay in IDLE; all outputs are held except ack=0 and rsp_valid=0.
//  - Requester rule: hold req[i] and din[i] stable until ack[i] is seen; deassert req[i] in the
//    ack cycle. req[i] still high in a later IDLE is a NEW request.
//  - Dropping req[i] before grant is legal; that request is then never acked.
//  - req/din changes while busy are ignored; arbitration is evaluated only in IDLE.
//  - CALC, one root bit per edge, MSB first, QW edges:
//    - t = {rem, rad[DW-1:DW-2]} - {root, 2'b01}; rad <<= 2.
//    - If t >= 0: rem=t, root={root,1}. Otherwise: rem={rem, rad bits}, root={root,0}.
//    - rem is QW+2 bits wide; the comparison is unsigned, with no overflow possible.
//    - After edge QW, go to DONE; rsp_data=root, rsp_id=id are registered on that edge.
//  - DONE: rsp_valid=1 for one cycle; next edge -> IDLE. rsp_data/rsp_id hold until the next result.
//  - Latency: grant edge E0 -> rsp_valid high in the cycle after edge E0+QW (QW+1 cycles).
//  - Next grant at E0+QW+2 at the earliest. Throughput is 1 result per QW+2 cycles.
//  - busy=1 from the cycle after E0 through the DONE cycle inclusive.
//  - Fairness: with k requesters held high, each gets one grant per k operations, in
//    ascending index order with wrap.
//  - Exactness: rsp_data^2 <= din < (rsp_data+1)^2 for all din in [0, 2^DW-1].
// TESTING
//  1) req=6'b000001, din0=1600 -> ack=000001 1 cycle after grant; rsp_valid 21 cycles after
//     grant edge; id=0, data=40.
//  2) req=6'b111111 at once, each dropped on its ack -> acks/results in order id 0,1,2,3,4,5.
//     Grant spacing is exactly 22 cycles.
//  3) req[1], req[3] held high permanently -> grant order 1,3,1,3,...; never two in a row.
//  4) Boundaries, one per run -> results as follows:
//     din=0 -> 0; din=24 -> 4; din=25 -> 5; din=2^40-1 -> 1048575; din=2^40-2^21+1 -> 1048575.
//  5) reset pulsed at cycle 10 of CALC -> no rsp_valid, all outputs 0; then req=6'b100001
//     -> id 0 granted first.
//  6) req[2] high 1 cycle while busy, then low -> never acked; req[2] toggled during CALC
//     -> result of the current op unchanged.

Source files
------------

// File: rtl/sqrt_share_sched.sv
// Round-robin scheduler sharing one restoring square-root engine; result QW+1 cycles after grant.
// No backpressure: one operation in flight, requesters hold req/din until their ack pulse.
module sqrt_share_sched #(
  parameter int NREQ = 6,
  parameter int DW   = 40,
  parameter int QW   = 20,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [QW-1:0]        rsp_data
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q;
  logic [NREQ-1:0]   ack_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [QW-1:0]     rsp_data_q;
  logic [IDW-1:0]    last_id_q;
  logic [DW-1:0]     rad_q, rad_d;
  logic [QW+1:0]     rem_q, rem_d;
  logic [QW-1:0]     root_q, root_d;
  logic [CW-1:0]     cnt_q;

  logic              hi_vld;
  logic [IDW-1:0]    hi_id, lo_id, grant_id;
  logic [DW-1:0]     rad_sel;

  // Lowest requester above last_id wins; otherwise wrap to the lowest set bit.
  always_comb begin
    hi_vld  = 1'b0;
    hi_id   = '0;
    lo_id   = '0;
    rad_sel = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_id = IDW'(i);
        if (IDW'(i) > last_id_q) begin
          hi_vld = 1'b1;
          hi_id  = IDW'(i);
        end
      end
    end
    grant_id = hi_vld ? hi_id : lo_id;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) rad_sel = din[i*DW +: DW];
    end
  end

  logic [QW+3:0] cur;
  logic [QW+1:0] trial;
  logic          take;

  // The difference always fits in QW+2 bits whenever the trial subtraction succeeds.
  always_comb begin
    cur   = {rem_q, rad_q[DW-1:DW-2]};
    take  = (cur >= {2'b00, root_q, 2'b01});
    trial = cur[QW+1:0] - {root_q, 2'b01};
    rad_d = {rad_q[DW-3:0], 2'b00};
    if (take) begin
      rem_d  = trial;
      root_d = {root_q[QW-2:0], 1'b1};
    end else begin
      rem_d  = cur[QW+1:0];
      root_d = {root_q[QW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      last_id_q   <= IDW'(NREQ - 1);
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
    end else begin
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q   <= CALC;
            ack_q     <= NREQ'(1) << grant_id;
            busy_q    <= 1'b1;
            last_id_q <= grant_id;
            rad_q     <= rad_sel;
            rem_q     <= '0;
            root_q    <= '0;
            cnt_q     <= '0;
          end
        end
        CALC: begin
          rad_q  <= rad_d;
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(QW - 1)) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= root_d;
            rsp_id_q    <= last_id_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
